spi_slave_module: RTL and testbench

- SPI mode-0 responder (slave): the far end of the team's SPI master link.
- Oversamples SCK/CS/MOSI in the local clk domain.
- Deserialises MOSI MSB-first into bytes and serialises a host-supplied byte onto MISO in the same frame.
- Sits between the external SPI pins and an internal register/command block.

---
 rtl/spi_slave_module_pkg.sv | 11 +
 rtl/spi_slave_module_if.sv | 32 +++
 rtl/spi_slave_module_sync_edge.sv | 31 +++
 rtl/spi_slave_module.sv | 126 ++++++++++++
 tb/tb_spi_slave_module.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_module_pkg.sv
// Shared constants and state encoding for the SPI mode-0 responder.
package spi_slave_module_pkg;
  localparam int         SPI_DATA_W        = 8;
  localparam logic [7:0] SPI_UNDERRUN_BYTE = 8'h00;
  localparam int         SPI_MIN_SYNC      = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_t;
endpackage

// File: rtl/spi_slave_module_if.sv
// Pin-side and host-side signals of the SPI responder, grouped for port passing.
interface spi_slave_module_if
  import spi_slave_module_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W
);
  logic              I_spi_sck;
  logic              I_spi_cs;
  logic              I_spi_mosi;
  logic              O_spi_miso;
  logic              O_spi_miso_oe;
  logic [DATA_W-1:0] I_tx_data;
  logic              I_tx_valid;
  logic              O_tx_ready;
  logic [DATA_W-1:0] O_rx_data;
  logic              O_rx_valid;
  logic              O_tx_underrun;
  logic              O_frame_err;
  logic              O_busy;

  modport slave (
    input  I_spi_sck, I_spi_cs, I_spi_mosi, I_tx_data, I_tx_valid,
    output O_spi_miso, O_spi_miso_oe, O_tx_ready, O_rx_data, O_rx_valid,
           O_tx_underrun, O_frame_err, O_busy
  );

  modport master (
    output I_spi_sck, I_spi_cs, I_spi_mosi, I_tx_data, I_tx_valid,
    input  O_spi_miso, O_spi_miso_oe, O_tx_ready, O_rx_data, O_rx_valid,
           O_tx_underrun, O_frame_err, O_busy
  );
endinterface

// File: rtl/spi_slave_module_sync_edge.sv
// Multi-stage synchroniser for one SPI pin with rise/fall strobes.
module spi_slave_module_sync_edge
  import spi_slave_module_pkg::*;
#(
  parameter int   STAGES  = SPI_MIN_SYNC,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);
  logic [STAGES-1:0] r_sync;
  logic              r_dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RST_VAL}};
      r_dly  <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_pin};
      r_dly  <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  = r_sync[STAGES-1] & ~r_dly;
  assign o_fall  = ~r_sync[STAGES-1] & r_dly;
endmodule

// File: rtl/spi_slave_module.sv
// SPI mode-0 responder: oversampled pins, MSB-first RX deserialiser and
// single-entry buffered TX serialiser sharing one bit counter.
module spi_slave_module
  import spi_slave_module_pkg::*;
#(
  parameter int              DATA_W        = SPI_DATA_W,
  parameter int              SYNC_STAGES   = 2,
  parameter logic [DATA_W-1:0] UNDERRUN_BYTE = DATA_W'(SPI_UNDERRUN_BYTE)
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_slave_module_if.slave   sif
);
  localparam int SYNC_N = (SYNC_STAGES < SPI_MIN_SYNC) ? SPI_MIN_SYNC : SYNC_STAGES;
  localparam int CNT_W  = $clog2(DATA_W);

  logic w_sck_lvl_unused, w_sck_rise, w_sck_fall;
  logic w_cs, w_cs_rise, w_cs_fall;
  logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

  spi_slave_module_sync_edge #(.STAGES(SYNC_N), .RST_VAL(1'b0)) u_sck (
    .clk(clk), .rst_n(rst_n), .i_pin(sif.I_spi_sck),
    .o_level(w_sck_lvl_unused), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );
  spi_slave_module_sync_edge #(.STAGES(SYNC_N), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst_n(rst_n), .i_pin(sif.I_spi_cs),
    .o_level(w_cs), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
  );
  spi_slave_module_sync_edge #(.STAGES(SYNC_N), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .i_pin(sif.I_spi_mosi),
    .o_level(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
  );

  spi_state_t        r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-2:0] r_rx_shift;
  logic [DATA_W-1:0] r_tx_shift;
  logic [DATA_W-1:0] r_tx_buf;
  logic              r_tx_full;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_underrun;
  logic              r_frame_err;

  logic w_accept, w_reload, w_cnt_last, w_cnt_zero;

  assign w_cnt_last = (r_bit_cnt == CNT_W'(DATA_W-1));
  assign w_cnt_zero = (r_bit_cnt == '0);
  assign w_accept   = sif.I_tx_valid & ~r_tx_full;
  // Reload at frame start, and at each byte boundary fall unless CS is leaving.
  assign w_reload   = ((r_state == ST_IDLE) & w_cs_fall) |
                      ((r_state == ST_ACTIVE) & ~w_cs_rise & w_sck_fall & w_cnt_zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_rx_shift  <= '0;
      r_tx_shift  <= UNDERRUN_BYTE;
      r_tx_buf    <= '0;
      r_tx_full   <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
      r_frame_err <= 1'b0;

      if (w_reload) begin
        if (r_tx_full) begin
          r_tx_shift <= r_tx_buf;
          r_tx_full  <= 1'b0;
        end else begin
          r_tx_shift <= UNDERRUN_BYTE;
          r_underrun <= 1'b1;
        end
      end

      // A reload from a full buffer never coincides with an accept (ready is low).
      if (w_accept) begin
        r_tx_buf  <= sif.I_tx_data;
        r_tx_full <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_state   <= ST_ACTIVE;
            r_bit_cnt <= '0;
          end
        end
        ST_ACTIVE: begin
          if (w_cs_rise) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            if (!w_cnt_zero) r_frame_err <= 1'b1;
          end else begin
            if (w_sck_rise) begin
              r_rx_shift <= {r_rx_shift[DATA_W-3:0], w_mosi};
              if (w_cnt_last) begin
                r_rx_data  <= {r_rx_shift, w_mosi};
                r_rx_valid <= 1'b1;
                r_bit_cnt  <= '0;
              end else begin
                r_bit_cnt  <= r_bit_cnt + 1'b1;
              end
            end
            if (w_sck_fall && !w_cnt_zero) r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sif.O_spi_miso    = (r_state == ST_ACTIVE) & r_tx_shift[DATA_W-1];
  assign sif.O_spi_miso_oe = (r_state == ST_ACTIVE);
  assign sif.O_tx_ready    = ~r_tx_full;
  assign sif.O_rx_data     = r_rx_data;
  assign sif.O_rx_valid    = r_rx_valid;
  assign sif.O_tx_underrun = r_underrun;
  assign sif.O_frame_err   = r_frame_err;
  assign sif.O_busy        = ~w_cs;
endmodule

// File: tb/tb_spi_slave_module.sv
// Bench for spi_slave_module: a mode-0 master drives frames while a monitor
// compares received bytes and pulse counts against a queue-based model.
module tb_spi_slave_module;
  import spi_slave_module_pkg::*;

  localparam int         HALF  = 4;
  localparam logic [7:0] UNDER = 8'h00;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  spi_slave_module_if #(.DATA_W(8)) sif();

  spi_slave_module #(.DATA_W(8), .SYNC_STAGES(2), .UNDERRUN_BYTE(8'h00)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sif(sif.slave)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_rx_q[$];
  logic [7:0] exp_miso_q[$];
  logic [7:0] buf_q[$];
  int exp_under = 0, exp_ferr = 0, act_under = 0, act_ferr = 0;
  logic [7:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (sif.O_rx_valid) begin
        if (exp_rx_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rx_unexpected: got %0h expected no byte", sif.O_rx_data);
        end else begin
          mon_e = exp_rx_q.pop_front();
          check("rx_data", sif.O_rx_data, mon_e);
        end
      end
      if (sif.O_tx_underrun) act_under++;
      if (sif.O_frame_err) act_ferr++;
    end
  end

  // Model: one-entry holding buffer; each reload takes it or the underrun byte.
  task automatic model_reload();
    if (buf_q.size() > 0) exp_miso_q.push_back(buf_q.pop_front());
    else begin
      exp_miso_q.push_back(UNDER);
      exp_under++;
    end
  endtask

  task automatic load_tx(input logic [7:0] b);
    check("tx_ready_before_load", sif.O_tx_ready, 1);
    sif.I_tx_data  = b;
    sif.I_tx_valid = 1'b1;
    @(negedge clk);
    sif.I_tx_valid = 1'b0;
    buf_q.push_back(b);
    @(negedge clk);
    check("tx_ready_after_load", sif.O_tx_ready, 0);
  endtask

  task automatic cs_start();
    sif.I_spi_cs = 1'b0;
    model_reload();
    repeat (HALF) @(negedge clk);
    check("tx_ready_after_csfall", sif.O_tx_ready, buf_q.size() == 0);
    check("busy_in_frame", sif.O_busy, 1);
    check("miso_oe_in_frame", sif.O_spi_miso_oe, 1);
  endtask

  task automatic xfer_byte(input logic [7:0] b, input int nbits, input bit last,
                           input bit do_load, input logic [7:0] ld);
    logic [7:0] got;
    logic [7:0] exp;
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      sif.I_spi_mosi = b[7-i];
      repeat (HALF) @(negedge clk);
      got[7-i] = sif.O_spi_miso;
      if (i == 0 && do_load) load_tx(ld);
      if (i == 7) exp_rx_q.push_back(b);
      sif.I_spi_sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sif.I_spi_sck = 1'b0;
      if (i == nbits - 1 && last) sif.I_spi_cs = 1'b1;
      else if (i == 7) model_reload();
    end
    if (exp_miso_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL miso_model_empty: got none expected a byte");
    end else begin
      exp = exp_miso_q.pop_front();
      if (nbits == 8) check("miso_byte", got, exp);
    end
    if (last && nbits != 8) exp_ferr++;
    if (last) repeat (HALF) @(negedge clk);
  endtask

  task automatic scenario_end(input string name);
    repeat (6) @(negedge clk);
    check({name, "_underruns"}, act_under, exp_under);
    check({name, "_frame_errs"}, act_ferr, exp_ferr);
    check({name, "_rx_pending"}, exp_rx_q.size(), 0);
    check({name, "_oe_idle"}, sif.O_spi_miso_oe, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    sif.I_spi_sck  = 1'b0;
    sif.I_spi_cs   = 1'b1;
    sif.I_spi_mosi = 1'b0;
    sif.I_tx_data  = '0;
    sif.I_tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso", sif.O_spi_miso, 0);
    check("rst_oe", sif.O_spi_miso_oe, 0);
    check("rst_ready", sif.O_tx_ready, 1);
    check("rst_rx_data", sif.O_rx_data, 0);
    check("rst_pulses", {sif.O_rx_valid, sif.O_tx_underrun, sif.O_frame_err}, 0);
    check("rst_busy", sif.O_busy, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    load_tx(8'hA5);
    cs_start();
    xfer_byte(8'h3C, 8, 1, 0, 8'h00);
    scenario_end("preload");

    cs_start();
    xfer_byte(8'hFF, 8, 1, 0, 8'h00);
    scenario_end("underrun");

    load_tx(8'hC3);
    cs_start();
    xfer_byte(8'h12, 8, 0, 1, 8'h5A);
    xfer_byte(8'h34, 8, 1, 0, 8'h00);
    scenario_end("b2b");

    cs_start();
    xfer_byte(8'hB7, 5, 1, 0, 8'h00);
    cs_start();
    xfer_byte(8'h81, 8, 1, 0, 8'h00);
    scenario_end("frame_err");

    cs_start();
    xfer_byte(8'h9D, 3, 0, 1, 8'h77);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_oe", sif.O_spi_miso_oe, 0);
    check("midrst_ready", sif.O_tx_ready, 1);
    check("midrst_rx_data", sif.O_rx_data, 0);
    check("midrst_miso", sif.O_spi_miso, 0);
    sif.I_spi_sck  = 1'b0;
    sif.I_spi_cs   = 1'b1;
    sif.I_spi_mosi = 1'b0;
    buf_q.delete();
    exp_miso_q.delete();
    exp_rx_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    cs_start();
    xfer_byte(8'h6E, 8, 1, 0, 8'h00);
    scenario_end("reset_mid");

    for (int k = 0; k < 10; k++) begin
      sif.I_spi_mosi = 1'($urandom);
      sif.I_spi_sck  = 1'b1;
      repeat (HALF) @(negedge clk);
      check("idle_sck_oe_hi", sif.O_spi_miso_oe, 0);
      sif.I_spi_sck  = 1'b0;
      repeat (HALF) @(negedge clk);
      check("idle_sck_oe_lo", sif.O_spi_miso_oe, 0);
    end
    scenario_end("idle_sck");

    for (int f = 0; f < 8; f++) begin
      int nb;
      if (buf_q.size() == 0 && ($urandom % 2) == 1) load_tx(8'($urandom));
      nb = 1 + int'($urandom % 3);
      cs_start();
      for (int k = 0; k < nb; k++)
        xfer_byte(8'($urandom), 8, k == nb - 1,
                  (buf_q.size() == 0) && (($urandom % 2) == 1), 8'($urandom));
      scenario_end("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
